// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared state encoding, default register addresses and status layout
// for the memory-mapped UART transmitter.
package mmio_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [31:0] DEF_TX_ADDR     = 32'h0000_0FF0;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_0FF4;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_EMPTY = 3;
    localparam int ST_CNT   = 4;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       full,
        input logic       ovf,
        input logic       empty,
        input logic [3:0] cnt
    );
        logic [31:0] s;
        s = '0;
        s[ST_BUSY]     = busy;
        s[ST_FULL]     = full;
        s[ST_OVF]      = ovf;
        s[ST_EMPTY]    = empty;
        s[ST_CNT +: 4] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO; dout shows the head entry combinationally while not empty.
module uart_tx_fifo
    import mmio_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wp, rp;
    logic        do_push, do_pop;

    // The extra pointer bit separates a full ring from an empty one.
    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count   = wp - rp;
    assign dout    = mem[rp[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MEM-stage UART transmitter; stores to TX_ADDR queue bytes, loads from
// STATUS_ADDR return busy/full/overflow/empty/count, Hit steers the load data mux.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        Tx,
    output logic        Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n, dout;
    logic [AW:0]   count;
    logic          ovf, ovf_n, tx_n, busy_n;
    logic          push, pop, full, empty, tick;
    logic          sel_tx, sel_st, wr_tx, clr;
    logic          unused_wdata;

    assign sel_tx       = Address == TX_ADDR;
    assign sel_st       = Address == STATUS_ADDR;
    assign wr_tx        = MemWrite && sel_tx;
    assign clr          = MemWrite && sel_st && WriteData[ST_OVF];
    assign push         = wr_tx && !full;
    assign unused_wdata = ^WriteData[31:8];

    // full is the pre-edge value, so a push is dropped even if a pop frees a slot this edge.
    assign ovf_n    = (wr_tx && full) || (ovf && !clr);
    assign Hit      = (MemRead || MemWrite) && (sel_tx || sel_st);
    assign ReadData = (MemRead && sel_st) ? pack_status(Busy, full, ovf, empty, 4'(count)) : '0;
    assign tick     = cnt == CW'(CLKS_PER_BIT - 1);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (WriteData[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = dout;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    idx_n   = idx + 1'b1;
                    state_n = idx == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                // Reload straight into START so consecutive frames have no idle gap.
                if (tick) begin
                    pop     = !empty;
                    shift_n = empty ? shift : dout;
                    state_n = empty ? IDLE : START;
                end
            end
            default: state_n = IDLE;
        endcase
        tx_n   = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
        busy_n = state_n != IDLE || !empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            ovf   <= 1'b0;
            Tx    <= 1'b1;
            Busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            ovf   <= ovf_n;
            Tx    <= tx_n;
            Busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized scenario bench; a queue-based transmitter model predicts
// frame contents and start cycles, a line monitor decodes what actually appears on Tx.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] TXA   = 32'h0000_0FF0;
    localparam logic [31:0] STA   = 32'h0000_0FF4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Hit, Tx, Busy;

    int n_chk = 0;
    int n_fail = 0;
    int ecyc = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_b[$];
    int         exp_s[$];
    logic [7:0] rx_b[$];
    int         rx_s[$];
    bit         rx_ok[$];
    bit         m_act = 0, m_ovf = 0, m_busy = 0;
    int         m_end = 0;

    mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .Tx        (Tx),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    // Reference: a byte queue feeding a transmitter that takes the next byte the edge it is free.
    initial forever begin
        bit pre_full, pre_ne;
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            m_act  = 0;
            m_ovf  = 0;
            m_busy = 0;
        end else begin
            ecyc++;
            pre_full = mq.size() == DEPTH;
            pre_ne   = mq.size() != 0;
            if (m_act && ecyc == m_end) m_act = 0;
            if (!m_act && pre_ne) begin
                exp_b.push_back(mq.pop_front());
                exp_s.push_back(ecyc);
                m_act = 1;
                m_end = ecyc + FRAME;
            end
            if (MemWrite && Address == TXA) begin
                if (pre_full) m_ovf = 1;
                else mq.push_back(WriteData[7:0]);
            end else if (MemWrite && Address == STA && WriteData[2]) m_ovf = 0;
            m_busy = m_act || pre_ne;
        end
    end

    // Line monitor: 40 samples per frame, bit value taken at the start of each bit period.
    initial forever begin
        int         st;
        bit         ok, ab, v;
        logic [7:0] b;
        @(negedge clk);
        if (!reset && Tx === 1'b0) begin
            st = ecyc;
            ok = 1;
            ab = 0;
            b  = '0;
            for (int k = 0; k < FRAME; k++) begin
                if (k > 0) @(negedge clk);
                if (reset) begin
                    ab = 1;
                    break;
                end
                v = Tx;
                if (k / CPB == 0) ok &= v == 1'b0;
                else if (k / CPB == 9) ok &= v == 1'b1;
                else if (k % CPB == 0) b[k / CPB - 1] = v;
                else ok &= v == b[k / CPB - 1];
            end
            if (!ab) begin
                rx_b.push_back(b);
                rx_s.push_back(st);
                rx_ok.push_back(ok);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] m_status();
        return {24'h0, 4'(mq.size()), mq.size() == 0, m_ovf, mq.size() == DEPTH, m_busy};
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        Address = a;
        WriteData = d;
        @(negedge clk);
        MemWrite = 1'b0;
        Address = '0;
        WriteData = '0;
    endtask

    task automatic flush();
        exp_b.delete();
        exp_s.delete();
        rx_b.delete();
        rx_s.delete();
        rx_ok.delete();
    endtask

    task automatic wait_idle(output bit to);
        to = 1;
        for (int i = 0; i < 800; i++) begin
            if (!m_act && mq.size() == 0) begin
                to = 0;
                break;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if (Tx !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_lines: Tx=%b Busy=%b, expected Tx=1 Busy=0", Tx, Busy);
        end
        MemRead = 1'b1;
        Address = STA;
        #1;
        n_chk++;
        if (ReadData !== 32'h8 || Hit !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_status: ReadData=%h Hit=%b, expected 00000008 Hit=1", ReadData, Hit);
        end
        MemRead = 1'b0;
        Address = '0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int e0, nb;
        bit to;
        flush();
        e0 = ecyc + 1;
        wr(TXA, 32'h55);
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            if (Busy) nb++;
            @(negedge clk);
        end
        wait_idle(to);
        n_chk++;
        if (to || rx_b.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d frames (timeout=%0d), expected 1", rx_b.size(), to);
        end
        if (rx_b.size() > 0) begin
            n_chk++;
            if (rx_b[0] !== 8'h55 || !rx_ok[0] || rx_s[0] != e0 + 1) begin
                n_fail++;
                $display("FAIL single_frame: byte=%h ok=%0d start=%0d, expected 55 ok=1 start=%0d",
                         rx_b[0], rx_ok[0], rx_s[0], e0 + 1);
            end
        end
        n_chk++;
        if (nb != FRAME) begin
            n_fail++;
            $display("FAIL single_busy: busy for %0d cycles, expected %0d", nb, FRAME);
        end
        n_chk++;
        if (Tx !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: Tx=%b Busy=%b, expected 1 0", Tx, Busy);
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        bit to;
        flush();
        wr(TXA, 32'hA3);
        wr(TXA, 32'h0F);
        nb = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (Busy) nb++;
        end
        wait_idle(to);
        n_chk++;
        if (to || rx_b.size() != 2 || exp_b.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d frames, expected 2", rx_b.size());
        end
        foreach (exp_b[i]) begin
            n_chk++;
            if (i >= rx_b.size() || rx_b[i] !== exp_b[i] || rx_s[i] != exp_s[i] || !rx_ok[i]) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: byte=%h start=%0d, expected %h start=%0d", i,
                         i < rx_b.size() ? rx_b[i] : 8'h0, i < rx_s.size() ? rx_s[i] : -1, exp_b[i], exp_s[i]);
            end
        end
        if (rx_b.size() == 2) begin
            n_chk++;
            if (rx_b[0] !== 8'hA3 || rx_b[1] !== 8'h0F || rx_s[1] - rx_s[0] != FRAME) begin
                n_fail++;
                $display("FAIL b2b_gap: bytes %h %h gap %0d, expected a3 0f gap %0d",
                         rx_b[0], rx_b[1], rx_s[1] - rx_s[0], FRAME);
            end
        end
        n_chk++;
        if (nb != 2 * FRAME) begin
            n_fail++;
            $display("FAIL b2b_busy: busy for %0d cycles, expected %0d", nb, 2 * FRAME);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d[6];
        bit to;
        flush();
        foreach (d[i]) d[i] = 8'($urandom);
        foreach (d[i]) wr(TXA, {24'h0, d[i]});
        MemRead = 1'b1;
        Address = STA;
        #1;
        n_chk++;
        if (ReadData !== m_status() || ReadData[2:1] !== 2'b11 || Hit !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_status: ReadData=%h Hit=%b, expected %h with full=1 ovf=1", ReadData, Hit, m_status());
        end
        MemRead = 1'b0;
        Address = '0;
        wait_idle(to);
        n_chk++;
        if (to || rx_b.size() != 5 || exp_b.size() != 5) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d frames, expected 5", rx_b.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (i >= rx_b.size() || rx_b[i] !== d[i] || !rx_ok[i] ||
                i >= exp_s.size() || rx_s[i] != exp_s[i]) begin
                n_fail++;
                $display("FAIL ovf_frame%0d: byte=%h, expected %h", i, i < rx_b.size() ? rx_b[i] : 8'h0, d[i]);
            end
        end
    endtask

    task automatic test_clear();
        wr(STA, 32'hFFFF_FFFB);
        MemRead = 1'b1;
        Address = STA;
        #1;
        n_chk++;
        if (ReadData !== m_status() || ReadData[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL noclear: ReadData=%h, expected %h (ovf still 1)", ReadData, m_status());
        end
        MemRead = 1'b0;
        wr(STA, 32'h4);
        MemRead = 1'b1;
        Address = STA;
        #1;
        n_chk++;
        if (ReadData !== m_status() || ReadData[2] !== 1'b0 || Hit !== 1'b1) begin
            n_fail++;
            $display("FAIL clear: ReadData=%h Hit=%b, expected %h Hit=1", ReadData, Hit, m_status());
        end
        Address = 32'h100;
        #1;
        n_chk++;
        if (ReadData !== 32'h0 || Hit !== 1'b0) begin
            n_fail++;
            $display("FAIL miss: ReadData=%h Hit=%b, expected 0 0", ReadData, Hit);
        end
        Address = TXA;
        #1;
        n_chk++;
        if (ReadData !== 32'h0 || Hit !== 1'b1) begin
            n_fail++;
            $display("FAIL txload: ReadData=%h Hit=%b, expected 0 1", ReadData, Hit);
        end
        MemRead = 1'b0;
        Address = STA;
        #1;
        n_chk++;
        if (ReadData !== 32'h0 || Hit !== 1'b0) begin
            n_fail++;
            $display("FAIL nostrobe: ReadData=%h Hit=%b, expected 0 0", ReadData, Hit);
        end
        Address = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int nlow;
        flush();
        for (int i = 0; i < 3; i++) wr(TXA, $urandom);
        repeat (16) @(negedge clk);
        reset = 1'b1;
        #1;
        n_chk++;
        if (Tx !== 1'b1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_lines: Tx=%b Busy=%b, expected 1 0", Tx, Busy);
        end
        MemRead = 1'b1;
        Address = STA;
        #1;
        n_chk++;
        if (ReadData !== 32'h8) begin
            n_fail++;
            $display("FAIL rst_mid_status: ReadData=%h, expected 00000008", ReadData);
        end
        MemRead = 1'b0;
        Address = '0;
        @(negedge clk);
        reset = 1'b0;
        flush();
        nlow = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (Tx !== 1'b1) nlow++;
        end
        n_chk++;
        if (nlow != 0 || rx_b.size() != 0 || exp_b.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: low cycles=%0d frames=%0d, expected 0 0", nlow, rx_b.size());
        end
    endtask

    task automatic test_pop_push();
        logic [7:0] d[3];
        int e;
        bit to;
        flush();
        foreach (d[i]) d[i] = 8'($urandom);
        e = ecyc + 1;
        wr(TXA, {24'h0, d[0]});
        wr(TXA, {24'h0, d[1]});
        while (ecyc < e + FRAME) @(negedge clk);
        wr(TXA, {24'h0, d[2]});
        MemRead = 1'b1;
        Address = STA;
        #1;
        n_chk++;
        if (ReadData[7:4] !== 4'd1 || ReadData !== m_status()) begin
            n_fail++;
            $display("FAIL poppush_count: ReadData=%h, expected %h with count 1", ReadData, m_status());
        end
        MemRead = 1'b0;
        Address = '0;
        wait_idle(to);
        n_chk++;
        if (to || rx_b.size() != 3) begin
            n_fail++;
            $display("FAIL poppush_frames: got %0d frames, expected 3", rx_b.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (i >= rx_b.size() || rx_b[i] !== d[i] || !rx_ok[i] || rx_s[i] != e + 1 + i * FRAME) begin
                n_fail++;
                $display("FAIL poppush_frame%0d: byte=%h start=%0d, expected %h start=%0d", i,
                         i < rx_b.size() ? rx_b[i] : 8'h0, i < rx_s.size() ? rx_s[i] : -1, d[i], e + 1 + i * FRAME);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        for (int r = 0; r < 4; r++) begin
            flush();
            for (int j = 0, n = $urandom_range(1, 7); j < n; j++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if ($urandom_range(0, 5) == 0) wr(STA, $urandom);
                else wr(TXA, $urandom);
            end
            MemRead = 1'b1;
            Address = STA;
            #1;
            n_chk++;
            if (ReadData !== m_status()) begin
                n_fail++;
                $display("FAIL rand%0d_status: ReadData=%h, expected %h", r, ReadData, m_status());
            end
            MemRead = 1'b0;
            Address = '0;
            wait_idle(to);
            n_chk++;
            if (to || rx_b.size() != exp_b.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d frames, expected %0d", r, rx_b.size(), exp_b.size());
            end
            foreach (exp_b[i]) begin
                n_chk++;
                if (i >= rx_b.size() || rx_b[i] !== exp_b[i] || rx_s[i] != exp_s[i] || !rx_ok[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_frame%0d: byte=%h start=%0d, expected %h start=%0d", r, i,
                             i < rx_b.size() ? rx_b[i] : 8'h0, i < rx_s.size() ? rx_s[i] : -1, exp_b[i], exp_s[i]);
                end
            end
            wr(STA, 32'h4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_clear();
        test_reset_mid();
        test_pop_push();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
